// File: rtl/ram_clr_pkg.sv
// Shared definitions for the clearable word RAM: controller state encoding
// and the default geometry used by the datapath RAM instances.
package ram_clr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_AW    = 3;

endpackage

// File: rtl/ram_clr_ctrl.sv
// Control half of ram_clr: IDLE/SWEEP state machine, sweep pointer, BUSY
// and the write-port select (user write vs. zeroing write).
module ram_clr_ctrl
  import ram_clr_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] address,
  output logic          busy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_zero
);

  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          addr_ok;

  assign addr_ok = ({1'b0, address} < DEPTH_EXT);

  // Busy is forced while reset is held, before the state register has settled.
  assign busy = reset | (state_q == SWEEP);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = address;
    wr_zero = 1'b0;
    if (!reset) begin
      unique case (state_q)
        SWEEP: begin
          wr_en   = 1'b1;
          wr_addr = ptr_q;
          wr_zero = 1'b1;
          if (ptr_q == LAST_PTR) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
        IDLE: begin
          // A clear request wins over a same-cycle load; the sweep zeroes it anyway.
          if (clear) begin
            state_d = SWEEP;
            ptr_d   = '0;
          end else if (load && addr_ok) begin
            wr_en = 1'b1;
          end
        end
        default: begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_clr.sv
// Word-addressable RAM with combinational read, synchronous write and a
// built-in zeroing sweep after reset or on CLEAR.
module ram_clr
  import ram_clr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    ADDRESS,
  input  logic             LOAD,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] OUT,
  output logic             BUSY
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic             wr_en;
  logic             wr_zero;
  logic [AW-1:0]    wr_addr;

  ram_clr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk     (CLK),
    .reset   (RESET),
    .load    (LOAD),
    .clear   (CLEAR),
    .address (ADDRESS),
    .busy    (BUSY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_zero (wr_zero)
  );

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == AW'(i))) begin
        mem_d[i] = wr_zero ? '0 : IN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Addresses at or beyond DEPTH match no word and therefore read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ADDRESS == AW'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  assign OUT = BUSY ? '0 : rd_data;

endmodule

// File: doc/ram_clr.md
Name: ram_clr

Overview:
- Parametrised word-addressable RAM: the successor to the single-bit BIT and fixed-width register storage in Memory.v.
- Array of DEPTH words of WIDTH bits.
  - Combinational read.
  - Write on LOAD, synchronous to the clock.
- Built-in sequential clear engine zeroes every word after reset or on CLEAR request, reporting progress on BUSY.
- Serves as the data/stack RAM for the computer datapath.

Parameters:
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of words (≥2; need not be a power of two)
- AW, 3, address width; constraint DEPTH ≤ 2^AW

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- IN  input  WIDTH  write data
- ADDRESS  input  AW  read/write word address
- LOAD  input  1  write enable: mem[ADDRESS] <= IN at next rising edge
- CLEAR  input  1  request a full zeroing sweep
- OUT  output  WIDTH  read data, combinational from ADDRESS
- BUSY  output  1  clear sweep in progress; LOAD is ignored while high

Behaviour:
- Interface: one clock, CLK. RESET is synchronous and active-high, sampled only on CLK rising edge.
- State machine has two states, IDLE and SWEEP, with sweep pointer ptr[AW-1:0].
- Reset:
  - Any edge with RESET=1 sets state<=SWEEP and ptr<=0. No memory write occurs on that edge.
  - While RESET=1, BUSY=1 and OUT=0. These are the reset values of all outputs.
  - Memory contents are undefined until the sweep completes.
- SWEEP (RESET=0): each edge writes mem[ptr]<=0 and sets ptr<=ptr+1.
  - The edge that writes mem[DEPTH-1] sets state<=IDLE and ptr<=0.
  - BUSY therefore stays high for exactly DEPTH rising edges after RESET falls. It drops combinationally after the final write edge.
- IDLE:
  - LOAD=1 writes mem[ADDRESS]<=IN on the edge.
  - CLEAR=1 moves to SWEEP with ptr<=0.
- Simultaneous LOAD and CLEAR in IDLE: CLEAR wins and the write is dropped. The sweep would zero the word anyway.
- CLEAR while in SWEEP is ignored; the sweep does not restart.
- RESET in the middle of a sweep restarts it from ptr=0.
- LOAD while BUSY=1 is ignored: no write, no queueing.
- Read path: OUT = mem[ADDRESS] combinationally when IDLE. There is no read latency.
  - A write is visible on OUT immediately after the write edge, not before (no bypass).
  - OUT is forced to 0 whenever BUSY=1.
- Out-of-range address (ADDRESS ≥ DEPTH): writes are ignored and OUT reads 0. The sweep never addresses beyond DEPTH-1.
- Arithmetic: ptr increments are AW bits wide. The terminal compare is against DEPTH-1, so there is no wrap past DEPTH.
- Unknown/X on LOAD or CLEAR during RESET=1 has no effect.

Decomposition:
- Shared package/header (memory_defs): state encodings IDLE=1'b0 and SWEEP=1'b1, plus default WIDTH/DEPTH constants used by datapath RAM instances.
- One natural sub-module: ram_clr_ctrl (FSM + ptr + BUSY + write-mux select). The storage array and read mux stay in ram_clr.
- A separate clog2 helper is not required; AW is passed explicitly.

Test Plan (WIDTH=16, DEPTH=8, AW=3):
1. RESET high for 2 edges, then low:
   - BUSY=1 for exactly 8 edges, then 0.
   - OUT=0 throughout.
   - After BUSY falls, reading ADDRESS 0..7 gives 0 on every word.
2. IDLE writes:
   - LOAD IN=16'hBEEF at ADDRESS=3; OUT reads 16'hBEEF at ADDRESS=3 right after the edge.
   - LOAD=0 with IN=16'h1234 leaves mem[3]=16'hBEEF.
   - ADDRESS=4 still reads 0.
3. Fill words 0..7 with 16'h0011..16'h0088, then pulse CLEAR:
   - BUSY high for 8 edges.
   - A LOAD of 16'hFFFF to ADDRESS=5 issued during BUSY is dropped.
   - All words read 0 afterwards.
4. LOAD (IN=16'hAAAA, ADDRESS=2) and CLEAR in the same IDLE edge: sweep starts and mem[2]=0 after completion.
5. RESET asserted after 3 sweep edges:
   - Sweep restarts; BUSY lasts a full 8 edges after RESET release.
   - A CLEAR pulse mid-sweep does not extend BUSY.
6. Out-of-range address: DEPTH=6 instance (AW=3).
   - LOAD at ADDRESS=7 is ignored and OUT reads 0 there.
   - Sweep completes in 6 edges.
